// File: rtl/math_pkg.sv
// Shared types for the trig scheduler. The fixed-point widths come from the INT_BITS/FLOAT_BITS
// macros; these defaults apply only when constants.h has not already defined them.
`ifndef INT_BITS
`define INT_BITS 10
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 12
`endif

package math_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SIN  = 2'd1,
      COS  = 2'd2,
      RESP = 2'd3
   } trig_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr, wrapping to index 0.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      // First pass covers [ptr, N-1]; the second pass covers the wrap into [0, ptr-1].
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (IW'(i) >= ptr)) begin
            any       = 1'b1;
            grant_idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req[i]) begin
            any       = 1'b1;
            grant_idx = IW'(i);
         end
      end
      if (any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/sin_deg.sv
// Combinational sine of an integer angle in [-180, 180] degrees, using a quarter-wave table.
// The output is signed fixed point with 1.0 = 1024.
module sin_deg (
   input  logic [`INT_BITS-1:0]   deg,
   output logic [`FLOAT_BITS-1:0] sin_out
);

   localparam int AW = `INT_BITS;
   localparam int FW = `FLOAT_BITS;

   localparam int SIN_Q [0:90] = '{
         0,   18,   36,   54,   71,   89,  107,  125,  143,  160,
       178,  195,  213,  230,  248,  265,  282,  299,  316,  333,
       350,  367,  384,  400,  416,  433,  449,  465,  481,  496,
       512,  527,  543,  558,  573,  587,  602,  616,  630,  644,
       658,  672,  685,  698,  711,  724,  737,  749,  761,  773,
       784,  796,  807,  818,  828,  839,  849,  859,  868,  878,
       887,  896,  904,  912,  920,  928,  935,  943,  949,  956,
       962,  968,  974,  979,  984,  989,  994,  998, 1002, 1005,
      1008, 1011, 1014, 1016, 1018, 1020, 1022, 1023, 1023, 1024,
      1024
   };

   logic          neg;
   logic [AW-1:0] mag;
   logic [6:0]    q;
   logic [FW-1:0] qv;

   always_comb begin
      neg = deg[AW-1];
      mag = neg ? (~deg + 1'b1) : deg;
      // Fold (90, 180] back onto [0, 90) because sin(x) = sin(180 - x).
      q   = 7'((mag > AW'(90)) ? (AW'(180) - mag) : mag);
      qv  = FW'(SIN_Q[q]);
      sin_out = neg ? (~qv + 1'b1) : qv;
   end

endmodule

// File: rtl/trig_scheduler.sv
// Shares one sin_deg evaluator among N_REQ requesters: a round-robin grant, then sin, then cos
// (as sin(a+90)) on consecutive cycles, then a response held until its owner takes it.
module trig_scheduler
   import math_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*`INT_BITS-1:0] req_angle,
   output logic [N_REQ-1:0]           req_ready,
   output logic [N_REQ-1:0]           resp_valid,
   output logic [`FLOAT_BITS-1:0]     resp_sin,
   output logic [`FLOAT_BITS-1:0]     resp_cos,
   input  logic [N_REQ-1:0]           resp_ready,
   output logic [1:0]                 dbg_state
);

   localparam int IW = $clog2(N_REQ);
   localparam int AW = `INT_BITS;
   localparam int FW = `FLOAT_BITS;
   localparam logic signed [AW-1:0] P180 = AW'(180);
   localparam logic signed [AW-1:0] M180 = AW'(-180);
   localparam logic signed [AW-1:0] D360 = AW'(360);
   localparam logic signed [AW-1:0] D90  = AW'(90);

   trig_state_t          state;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        owner;
   logic signed [AW-1:0] a;
   logic signed [AW-1:0] sel_angle;
   logic signed [AW-1:0] norm_angle;
   logic signed [AW-1:0] cos_angle;
   logic [AW-1:0]        sin_in;
   logic [FW-1:0]        sin_out;
   logic [FW-1:0]        sin_r;
   logic [FW-1:0]        cos_r;
   logic [N_REQ-1:0]     grant;
   logic [IW-1:0]        grant_idx;
   logic                 any;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   sin_deg u_sin (
      .deg     (sin_in),
      .sin_out (sin_out)
   );

   // Request side: req_valid[i] holds until req_ready[i]. A transfer happens on a clock edge where
   // both are high. Response side: resp_valid[owner] and the data hold until resp_ready[owner].
   assign req_ready = (state == IDLE && any) ? grant : '0;
   assign resp_sin  = sin_r;
   assign resp_cos  = cos_r;
   assign dbg_state = state;

   always_comb begin
      sel_angle = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) sel_angle = req_angle[i*AW +: AW];
      end
      norm_angle = sel_angle;
      if (sel_angle > P180)      norm_angle = sel_angle - D360;
      else if (sel_angle < M180) norm_angle = sel_angle + D360;
      cos_angle = a + D90;
      if (cos_angle > P180) cos_angle = cos_angle - D360;
      // The shared input idles at 0 outside SIN/COS so the trig datapath stays quiet.
      case (state)
         SIN:     sin_in = a;
         COS:     sin_in = cos_angle;
         default: sin_in = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         a          <= '0;
         sin_r      <= '0;
         cos_r      <= '0;
         resp_valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  a      <= norm_angle;
                  owner  <= grant_idx;
                  rr_ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                  state  <= SIN;
               end
            end
            SIN: begin
               sin_r <= sin_out;
               state <= COS;
            end
            COS: begin
               cos_r      <= sin_out;
               resp_valid <= N_REQ'(1) << owner;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready[owner]) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   angle_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      (state == IDLE && any) |-> (sel_angle >= -359 && sel_angle <= 359));

endmodule

// File: tb/tb_trig_scheduler.sv
// Directed bench for trig_scheduler: single request, normalisation, round-robin order,
// back-pressure, and asynchronous reset during a transaction.
`ifndef INT_BITS
`define INT_BITS 10
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 12
`endif

module tb_trig_scheduler;
   import math_pkg::*;

   localparam int N_REQ = 4;
   localparam int AW    = `INT_BITS;
   localparam int FW    = `FLOAT_BITS;

   logic                    clk;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*AW-1:0]     req_angle;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        resp_valid;
   logic signed [FW-1:0]    resp_sin;
   logic signed [FW-1:0]    resp_cos;
   logic [N_REQ-1:0]        resp_ready;
   logic [1:0]              dbg_state;

   int n_checks;
   int n_fail;
   logic [N_REQ-1:0] exp_q[$];

   // Hand-computed values at 1.0 = 1024: angle, round(1024*sin), round(1024*cos).
   int vang [8] = '{  270, -270,   180,  -180,    0,  359,  -45,  200};
   int vsin [8] = '{-1024, 1024,     0,     0,    0,  -18, -724, -350};
   int vcos [8] = '{    0,    0, -1024, -1024, 1024, 1024,  724, -962};
   // Round-robin angles per requester (0, 30, -45, 180) and their expected sines.
   int rr_ang [4] = '{0, 30, -45, 180};
   int rr_sin [4] = '{0, 512, -724, 0};

   trig_scheduler #(.N_REQ(N_REQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_angle  (req_angle),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_sin   (resp_sin),
      .resp_cos   (resp_cos),
      .resp_ready (resp_ready),
      .dbg_state  (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required end before 200000 time units");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      logic signed [31:0] d;
      n_checks++;
      d = obs - exp;
      assert (d >= -1 && d <= 1) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (+/-1)", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic set_angle(input int idx, input int angle);
      req_angle[idx*AW +: AW] = AW'(angle);
   endtask

   task automatic apply_reset(input logic [N_REQ-1:0] v);
      rst_n      = 1'b0;
      req_valid  = v;
      resp_ready = '1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic wait_resp(input string tag);
      int cnt;
      cnt = 0;
      while (resp_valid === '0 && cnt < 12) begin
         @(negedge clk); #1;
         cnt++;
      end
      chk({tag, "_resp_seen"}, 32'(resp_valid !== '0), 1);
   endtask

   task automatic run_one(input int idx, input int angle, input int esin, input int ecos, input string tag);
      int cnt;
      logic [N_REQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      set_angle(idx, angle);
      req_valid[idx] = 1'b1;
      #1;
      cnt = 0;
      while (req_ready !== oh && cnt < 20) begin
         @(negedge clk); #1;
         cnt++;
      end
      chk({tag, "_grant"}, req_ready, oh);
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
      @(negedge clk); #1;
      chk({tag, "_t1_state"}, dbg_state, SIN);
      chk({tag, "_t1_valid"}, resp_valid, 0);
      @(negedge clk); #1;
      chk({tag, "_t2_valid"}, resp_valid, 0);
      @(negedge clk); #1;
      chk({tag, "_t3_valid"}, resp_valid, oh);
      chk_near({tag, "_sin"}, resp_sin, esin);
      chk_near({tag, "_cos"}, resp_cos, ecos);
      @(negedge clk); #1;
      chk({tag, "_t4_valid"}, resp_valid, 0);
      chk({tag, "_t4_state"}, dbg_state, IDLE);
   endtask

   initial begin
      logic [N_REQ-1:0] exp_oh;
      logic [N_REQ-1:0] gexp;
      int grants;
      int cyc;
      int own;

      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_angle  = '0;
      resp_ready = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_sin", resp_sin, 0);
      chk("rst_resp_cos", resp_cos, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_state", dbg_state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      resp_ready = '1;
      #1;

      // Single request: requester 1, 30 degrees
      run_one(1, 30, 512, 887, "single_30");

      // Normalisation and wrap, spread over the requesters
      for (int k = 0; k < 8; k++) begin
         run_one(k % 4, vang[k], vsin[k], vcos[k], $sformatf("norm_%0d", vang[k]));
      end

      // All requesters valid continuously from reset
      for (int i = 0; i < N_REQ; i++) set_angle(i, rr_ang[i]);
      for (int k = 0; k < 8; k++) exp_q.push_back(N_REQ'(1) << (k % 4));
      apply_reset('1);
      grants = 0;
      cyc = 0;
      while (cyc < 80 && exp_q.size() > 0) begin
         if (grants == 8 && dbg_state != IDLE) req_valid = '0;
         if (req_ready !== '0) begin
            gexp = N_REQ'(1) << (grants % 4);
            chk("rr_grant", req_ready, gexp);
            chk("rr_no_overlap", resp_valid, 0);
            grants++;
         end
         if (resp_valid !== '0) begin
            exp_oh = exp_q.pop_front();
            own = 0;
            for (int b = 0; b < N_REQ; b++) if (exp_oh[b]) own = b;
            chk("rr_owner", resp_valid, exp_oh);
            chk_near("rr_sin", resp_sin, rr_sin[own]);
         end
         @(negedge clk); #1;
         cyc++;
      end
      chk("rr_grants", grants, 8);
      chk("rr_responses_left", exp_q.size(), 0);
      req_valid = '0;
      repeat (6) @(negedge clk);
      #1;

      // Back-pressure: requester 2 withholds resp_ready; non-owner ready bits stay high
      apply_reset('0);
      resp_ready = 4'b1011;
      set_angle(2, 135);
      req_valid = 4'b0100;
      wait_resp("bp");
      chk("bp_valid", resp_valid, 4'b0100);
      chk("bp_sin", resp_sin, 724);
      chk("bp_cos", resp_cos, -724);
      set_angle(0, 60);
      req_valid = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         chk($sformatf("bp_hold%0d_valid", c), resp_valid, 4'b0100);
         chk($sformatf("bp_hold%0d_sin", c), resp_sin, 724);
         chk($sformatf("bp_hold%0d_cos", c), resp_cos, -724);
         chk($sformatf("bp_hold%0d_req_ready", c), req_ready, 0);
      end
      resp_ready = 4'b1111;
      @(negedge clk); #1;
      chk("bp_release_valid", resp_valid, 0);
      chk("bp_release_grant", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp("bp_next");
      chk("bp_next_owner", resp_valid, 4'b0001);
      chk_near("bp_next_sin", resp_sin, 887);
      chk_near("bp_next_cos", resp_cos, 512);
      @(negedge clk); #1;

      // Reset during COS aborts the transaction; next grant starts from pointer 0
      apply_reset('0);
      set_angle(1, 30);
      req_valid = 4'b0010;
      #1;
      chk("abort_grant1", req_ready, 4'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      chk("abort_sin_state", dbg_state, SIN);
      @(negedge clk); #1;
      chk("abort_cos_state", dbg_state, COS);
      rst_n = 1'b0;
      #1;
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_resp_sin", resp_sin, 0);
      chk("abort_resp_cos", resp_cos, 0);
      chk("abort_req_ready", req_ready, 0);
      chk("abort_state", dbg_state, IDLE);
      set_angle(0, -45);
      req_valid = '1;
      repeat (2) @(negedge clk);
      chk("abort_no_resp", resp_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("abort_first_grant", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp("abort_after");
      chk("abort_after_owner", resp_valid, 4'b0001);
      chk_near("abort_after_sin", resp_sin, -724);
      @(negedge clk); #1;

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
